// File: rtl/alu_sequencer_if.sv
// Command, operand-memory, ALU and result signals of the accumulator sequencer.
// The sequencer uses the slave modport; the command source, memory and ALU side use master.
interface alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_addr;
  logic             cmd_last;
  logic             mem_req;
  logic [WIDTH-1:0] mem_addr;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] AC;
  logic [WIDTH-1:0] BusOut;
  logic [3:0]       ALU_OP;
  logic [WIDTH-1:0] MEM_ID;
  logic [WIDTH-1:0] result_ac;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [CNT_W-1:0] res_count;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_last, mem_ack, mem_rdata, result_ac, res_ready,
    output cmd_ready, mem_req, mem_addr, AC, BusOut, ALU_OP, MEM_ID, res_valid, res_data, res_count
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_last, mem_ack, mem_rdata, result_ac, res_ready,
    input  cmd_ready, mem_req, mem_addr, AC, BusOut, ALU_OP, MEM_ID, res_valid, res_data, res_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// Accumulator command sequencer: fetches operands, drives one-hot ALU ops for one
// cycle per command and hands back the final AC plus the executed-command count.
module alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;
  localparam logic [1:0] OP_ADDMEM = 2'b11;

  state_t           r_state;
  logic [1:0]       r_op;
  logic             r_last;
  logic [WIDTH-1:0] r_ac;
  logic [WIDTH-1:0] r_bus;
  logic [WIDTH-1:0] r_mem_id;
  logic [WIDTH-1:0] r_mem_addr;
  logic [3:0]       r_alu_op;
  logic             r_mem_req;
  logic             r_cmd_ready;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_res_count;

  logic [3:0] w_onehot_in;
  logic [3:0] w_onehot_lat;
  assign w_onehot_in  = 4'b0001 << bus.cmd_op;
  assign w_onehot_lat = 4'b0001 << r_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_last      <= 1'b0;
      r_ac        <= '0;
      r_bus       <= '0;
      r_mem_id    <= '0;
      r_mem_addr  <= '0;
      r_alu_op    <= 4'b0000;
      r_mem_req   <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid && r_cmd_ready) begin
            r_op        <= bus.cmd_op;
            r_last      <= bus.cmd_last;
            r_mem_id    <= bus.cmd_addr;
            r_mem_addr  <= bus.cmd_addr;
            r_cmd_ready <= 1'b0;
            // ADDMEM carries its operand as the immediate, so no read is issued
            if (bus.cmd_op == OP_ADDMEM) begin
              r_alu_op <= w_onehot_in;
              r_state  <= S_EXEC;
            end else begin
              r_mem_req <= 1'b1;
              r_state   <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (bus.mem_ack) begin
            r_bus     <= bus.mem_rdata;
            r_mem_req <= 1'b0;
            r_alu_op  <= w_onehot_lat;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_ac     <= bus.result_ac;
          r_alu_op <= 4'b0000;
          if (r_res_count != {CNT_W{1'b1}})
            r_res_count <= r_res_count + 1'b1;
          if (r_last) begin
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_count <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.AC        = r_ac;
  assign bus.BusOut    = r_bus;
  assign bus.ALU_OP    = r_alu_op;
  assign bus.MEM_ID    = r_mem_id;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_ac;
  assign bus.res_count = r_res_count;
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 8, datapath/address width shared with the accumulator ALU.
REQ-002 Parameter: CNT_W, 4, width of executed-command counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-007 cmd_op  input  2  00=SET, 01=MUL, 10=ADD, 11=ADDMEM.
REQ-008 cmd_addr  input  WIDTH  operand memory address (ADDMEM: immediate added to AC).
REQ-009 cmd_last  input  1  final command of a sequence.
REQ-010 mem_req  output  1  operand read request.
REQ-011 mem_addr  output  WIDTH  operand read address.
REQ-012 mem_ack  input  1  read data valid this cycle.
REQ-013 mem_rdata  input  WIDTH  read data.
REQ-014 AC  output  WIDTH  accumulator register, to ALU.
REQ-015 BusOut  output  WIDTH  latched operand, to ALU.
REQ-016 ALU_OP  output  4  one-hot ALU opcode: SET=0001, MUL=0010, ADD=0100, ADDMEM=1000, hold=0000.
REQ-017 MEM_ID  output  WIDTH  latched cmd_addr, to ALU.
REQ-018 result_ac  input  WIDTH  ALU result (combinational from AC/BusOut/ALU_OP/MEM_ID).
REQ-019 res_valid  output  1  sequence result available.
REQ-020 res_ready  input  1  consumer accepts result.
REQ-021 res_data  output  WIDTH  final AC value.
REQ-022 res_count  output  CNT_W  commands executed in the sequence.

Function
REQ-023 States SHALL be IDLE, FETCH, EXEC, DONE; one-hot or binary encoding at implementer's choice.
REQ-024 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch op, cmd_addr (into MEM_ID and mem_addr), last; go FETCH for SET/MUL/ADD, EXEC for ADDMEM.
REQ-025 cmd_ready SHALL be 0 in every state except IDLE.
REQ-026 FETCH: mem_req=1, mem_addr stable; on mem_ack latch mem_rdata into BusOut, go EXEC; no timeout, waits indefinitely.
REQ-027 mem_ack outside FETCH SHALL be ignored; mem_req SHALL be 0 outside FETCH.
REQ-028 EXEC: exactly one cycle; ALU_OP = one-hot of latched op; AC <= result_ac at end of cycle; res_count increments (saturates at 2^CNT_W-1).
REQ-029 EXEC exit: last=1 -> DONE, else IDLE.
REQ-030 ALU_OP SHALL be 0000 in all states other than EXEC.
REQ-031 DONE: res_valid=1, res_data=AC, res_count held stable; on res_ready go IDLE and clear res_count to 0; AC retained.
REQ-032 res_valid SHALL be 0 outside DONE.
REQ-033 Latency: ADDMEM command accept to AC update = 2 cycles; memory command = 2 cycles + mem_ack wait; last command EXEC to res_valid = 1 cycle.
REQ-034 Arithmetic width: AC truncated to WIDTH bits (wrap-around, no saturation); overflow not flagged.
REQ-035 cmd_valid deasserted in IDLE: remain IDLE, all outputs hold.
REQ-036 res_ready asserted in same cycle res_valid rises: single-cycle DONE permitted.

Reset
REQ-037 rst_n=0 SHALL immediately force: state IDLE, AC=0, BusOut=0, MEM_ID=0, mem_addr=0, ALU_OP=0000, mem_req=0, res_valid=0, res_count=0; cmd_ready=1 once in IDLE.
REQ-038 Reset mid-FETCH or mid-DONE SHALL abandon the sequence; a later mem_ack for the dropped read SHALL be ignored.

Verification
REQ-039 SET@addr 3 (mem=5), MUL@4 (mem=6), ADD@5 (mem=7, last), ack 1 cycle after req -> res_data=37, res_count=3.
REQ-040 ADDMEM cmd_addr=0x10 last, AC=0x20 -> no mem_req, ALU_OP=1000 for one cycle, res_data=0x30 two cycles after accept.
REQ-041 SET 0xF0, ADD 0x20 last (WIDTH=8) -> res_data=0x10 (wrap).
REQ-042 mem_ack withheld 20 cycles in FETCH -> mem_req held, cmd_ready=0, ALU_OP=0000 throughout; completes on ack.
REQ-043 res_ready low 5 cycles in DONE -> res_valid/res_data stable, cmd_ready=0; new cmd accepted cycle after res_ready.
REQ-044 rst_n low during FETCH, stray mem_ack after release -> all outputs at reset values, state IDLE, AC=0.
